// File: rtl/ahb_lsu_bridge.sv
`default_nettype none
// ============================================================================
// ahb_lsu_bridge : core LSU to AHB-Lite SINGLE-transfer bridge
// Revision: 1.0
// ============================================================================
module ahb_lsu_bridge #(
  parameter int unsigned AWIDTH    = 32,
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              err_o,
  output logic              hsel_o,
  output logic [AWIDTH-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [DWIDTH-1:0] hrdata_i
);

  localparam logic [1:0] c_idle       = 2'd0;
  localparam logic [1:0] c_addr       = 2'd1;
  localparam logic [1:0] c_data       = 2'd2;
  localparam logic [1:0] c_gap        = 2'd3;
  localparam logic [1:0] c_htrans_idl = 2'b00;
  localparam logic [1:0] c_htrans_nsq = 2'b10;
  localparam logic [7:0] c_to_limit   = 8'(TO_CYCLES);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        size_q, size_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] rdata_q, rdata_d;

  logic [2:0] w_size_norm;
  logic       w_misaligned;
  logic [7:0] w_cnt_inc;
  logic       w_timeout;
  logic       w_bus_active;

  // Undefined size encodings are carried onto the bus as word transfers.
  assign w_size_norm  = (size_i > 3'd2) ? 3'd2 : size_i;
  assign w_misaligned = ((w_size_norm == 3'd1) && addr_i[0]) ||
                        ((w_size_norm == 3'd2) && (addr_i[1:0] != 2'b00));
  assign w_cnt_inc    = cnt_q + 8'd1;
  assign w_timeout    = (w_cnt_inc == c_to_limit);

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (state_q)
      c_idle: begin
        if (req_i) begin
          we_d    = we_i;
          size_d  = w_size_norm;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = 8'd0;
          if (w_misaligned) begin
            state_d  = c_gap;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            state_d = c_addr;
          end
        end
      end
      c_addr: begin
        if (hready_i) begin
          state_d = c_data;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_timeout) begin
            state_d  = c_gap;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      c_data: begin
        if (hready_i) begin
          state_d  = c_gap;
          rvalid_d = 1'b1;
          err_d    = hresp_i;
          rdata_d  = (!we_q && !hresp_i) ? hrdata_i : '0;
        end else begin
          cnt_d = w_cnt_inc;
          if (w_timeout) begin
            state_d  = c_gap;
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = c_idle;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= c_idle;
      we_q     <= 1'b0;
      size_q   <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 8'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Grant is masked while reset is held so no request is accepted and lost.
  assign gnt_o        = hresetn && (state_q == c_idle) && req_i;
  assign w_bus_active = (state_q == c_addr) || (state_q == c_data);

  assign hsel_o   = w_bus_active;
  assign htrans_o = (state_q == c_addr) ? c_htrans_nsq : c_htrans_idl;
  assign haddr_o  = w_bus_active ? addr_q : '0;
  assign hwrite_o = w_bus_active ? we_q : 1'b0;
  assign hsize_o  = w_bus_active ? size_q : 3'd0;
  assign hburst_o = 3'b000;
  assign hwdata_o = ((state_q == c_data) && we_q) ? wdata_q : '0;

  assign rvalid_o = rvalid_q;
  assign err_o    = err_q;
  assign rdata_o  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lsu_bridge.sv
`default_nettype none
// ============================================================================
// tb_ahb_lsu_bridge : directed self-checking bench for ahb_lsu_bridge
// Revision: 1.0
// ============================================================================
module tb_ahb_lsu_bridge;

  logic        hclk;
  logic        hresetn;
  logic        req_i;
  logic        we_i;
  logic [2:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        hsel_o;
  logic [31:0] haddr_o;
  logic [1:0]  htrans_o;
  logic        hwrite_o;
  logic [2:0]  hsize_o;
  logic [2:0]  hburst_o;
  logic [31:0] hwdata_o;
  logic        hready_i;
  logic        hresp_i;
  logic [31:0] hrdata_i;

  int errors = 0;
  int checks = 0;

  ahb_lsu_bridge #(.AWIDTH(32), .DWIDTH(32), .TO_CYCLES(8)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .req_i(req_i), .we_i(we_i), .size_i(size_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .hsel_o(hsel_o), .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o),
    .hsize_o(hsize_o), .hburst_o(hburst_o), .hwdata_o(hwdata_o),
    .hready_i(hready_i), .hresp_i(hresp_i), .hrdata_i(hrdata_i)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hresetn = 1'b0; req_i = 1'b0; we_i = 1'b0; size_i = 3'd0; addr_i = '0;
    wdata_i = '0; hready_i = 1'b1; hresp_i = 1'b0; hrdata_i = '0;
    tick(); tick();
    checks++; if ({gnt_o, rvalid_o, err_o, hsel_o, hwrite_o} !== 5'b0) begin errors++; $display("FAIL reset_ctl got=%b exp=00000", {gnt_o, rvalid_o, err_o, hsel_o, hwrite_o}); end
    checks++; if ({rdata_o, haddr_o, hwdata_o} !== 96'h0) begin errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", rdata_o, haddr_o, hwdata_o); end
    checks++; if ({htrans_o, hsize_o, hburst_o} !== 8'h0) begin errors++; $display("FAIL reset_ctl2 got=%b/%b/%b exp=0", htrans_o, hsize_o, hburst_o); end
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_read_zero_wait();
    req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h4000_0000; hrdata_i = 32'h3; hready_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rd_gnt got=%b exp=1", gnt_o); end
    tick();
    req_i = 1'b0;
    checks++; if ({hsel_o, htrans_o, hwrite_o, hsize_o} !== {1'b1, 2'b10, 1'b0, 3'd2}) begin errors++; $display("FAIL rd_addr_ctl got=%b%b%b%b exp=1100010", hsel_o, htrans_o, hwrite_o, hsize_o); end
    checks++; if (haddr_o !== 32'h4000_0000) begin errors++; $display("FAIL rd_haddr got=%h exp=40000000", haddr_o); end
    tick();
    checks++; if ({hsel_o, htrans_o, rvalid_o} !== {1'b1, 2'b00, 1'b0}) begin errors++; $display("FAIL rd_data_ctl got=%b%b%b exp=1000", hsel_o, htrans_o, rvalid_o); end
    tick();
    checks++; if ({rvalid_o, err_o, hsel_o} !== 3'b100) begin errors++; $display("FAIL rd_gap got=%b%b%b exp=100", rvalid_o, err_o, hsel_o); end
    checks++; if (rdata_o !== 32'h3) begin errors++; $display("FAIL rd_rdata got=%h exp=00000003", rdata_o); end
    checks++; if (haddr_o !== 32'h0) begin errors++; $display("FAIL rd_gap_haddr got=%h exp=0", haddr_o); end
    tick();
    checks++; if ({rvalid_o, rdata_o} !== 33'h0) begin errors++; $display("FAIL rd_after got=%b/%h exp=0", rvalid_o, rdata_o); end
  endtask

  task automatic test_write_wait();
    req_i = 1'b1; we_i = 1'b1; size_i = 3'd2; addr_i = 32'h4000_0004; wdata_i = 32'h5;
    hready_i = 1'b1; hrdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got=%b exp=1", gnt_o); end
    tick();
    req_i = 1'b0; wdata_i = 32'h0;
    checks++; if ({hwrite_o, haddr_o} !== {1'b1, 32'h4000_0004}) begin errors++; $display("FAIL wr_addr got=%b/%h exp=1/40000004", hwrite_o, haddr_o); end
    for (int i = 0; i < 3; i++) begin
      tick();
      hready_i = (i == 2);
      checks++; if ({hsel_o, htrans_o, hwdata_o} !== {1'b1, 2'b00, 32'h5}) begin errors++; $display("FAIL wr_data_%0d got=%b/%b/%h exp=1/00/00000005", i, hsel_o, htrans_o, hwdata_o); end
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL wr_early_rvalid_%0d got=%b exp=0", i, rvalid_o); end
    end
    tick();
    checks++; if ({rvalid_o, err_o, rdata_o} !== {1'b1, 1'b0, 32'h0}) begin errors++; $display("FAIL wr_resp got=%b/%b/%h exp=1/0/0", rvalid_o, err_o, rdata_o); end
    checks++; if ({hsel_o, hwdata_o} !== 33'h0) begin errors++; $display("FAIL wr_gap_bus got=%b/%h exp=0", hsel_o, hwdata_o); end
    tick();
  endtask

  task automatic test_misaligned();
    req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h4000_0002; hready_i = 1'b1; hrdata_i = 32'hFFFF_FFFF;
    #1;
    checks++; if ({gnt_o, hsel_o} !== 2'b10) begin errors++; $display("FAIL mis_gnt got=%b%b exp=10", gnt_o, hsel_o); end
    tick();
    req_i = 1'b1; size_i = 3'd1; addr_i = 32'h4000_0001;
    checks++; if ({rvalid_o, err_o, hsel_o, rdata_o} !== {3'b110, 32'h0}) begin errors++; $display("FAIL mis_resp got=%b%b%b/%h exp=110/0", rvalid_o, err_o, hsel_o, rdata_o); end
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL mis_gap_gnt got=%b exp=0", gnt_o); end
    tick();
    checks++; if ({gnt_o, rvalid_o} !== 2'b10) begin errors++; $display("FAIL mis_regnt got=%b%b exp=10", gnt_o, rvalid_o); end
    tick();
    req_i = 1'b0;
    checks++; if ({rvalid_o, err_o, hsel_o} !== 3'b110) begin errors++; $display("FAIL mis_half got=%b%b%b exp=110", rvalid_o, err_o, hsel_o); end
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h4000_0008; hready_i = 1'b0;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL to_gnt got=%b exp=1", gnt_o); end
    for (int i = 0; i < 8; i++) begin
      tick();
      req_i = 1'b0;
      if (!(hsel_o === 1'b1 && htrans_o === 2'b10 && rvalid_o === 1'b0)) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL to_hold bad_cycles=%0d exp=0", bad); end
    tick();
    checks++; if ({rvalid_o, err_o, hsel_o, htrans_o, rdata_o} !== {5'b11000, 32'h0}) begin errors++; $display("FAIL to_abort got=%b%b%b%b/%h exp=11000/0", rvalid_o, err_o, hsel_o, htrans_o, rdata_o); end
    tick();
    hready_i = 1'b1;
    checks++; if ({rvalid_o, hsel_o} !== 2'b00) begin errors++; $display("FAIL to_idle got=%b%b exp=00", rvalid_o, hsel_o); end
    // cumulative count: 3 low cycles in ADDR then 5 in DATA
    req_i = 1'b1; addr_i = 32'h4000_000C; hready_i = 1'b0;
    tick(); req_i = 1'b0;
    tick(); tick(); tick();
    hready_i = 1'b1;
    tick();
    hready_i = 1'b0;
    checks++; if ({hsel_o, htrans_o} !== 3'b100) begin errors++; $display("FAIL to_cum_data got=%b%b exp=100", hsel_o, htrans_o); end
    tick(); tick(); tick(); tick();
    checks++; if ({hsel_o, rvalid_o} !== 2'b10) begin errors++; $display("FAIL to_cum_hold got=%b%b exp=10", hsel_o, rvalid_o); end
    tick();
    checks++; if ({rvalid_o, err_o, hsel_o} !== 3'b110) begin errors++; $display("FAIL to_cum_abort got=%b%b%b exp=110", rvalid_o, err_o, hsel_o); end
    tick();
    hready_i = 1'b1;
    req_i = 1'b1; addr_i = 32'h4000_0010; hrdata_i = 32'h1234_5678;
    tick(); req_i = 1'b0;
    tick(); tick();
    checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h1234_5678}) begin errors++; $display("FAIL to_recover got=%b%b/%h exp=10/12345678", rvalid_o, err_o, rdata_o); end
    tick();
  endtask

  task automatic test_slave_error();
    req_i = 1'b1; we_i = 1'b0; size_i = 3'd2; addr_i = 32'h4000_0014; hready_i = 1'b1; hrdata_i = 32'h0000_FFFF;
    tick(); req_i = 1'b0;
    tick(); hresp_i = 1'b1;
    tick(); hresp_i = 1'b0;
    checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b11, 32'h0}) begin errors++; $display("FAIL serr_resp got=%b%b/%h exp=11/0", rvalid_o, err_o, rdata_o); end
    tick();
    // hresp with hready low in DATA must be ignored
    req_i = 1'b1; addr_i = 32'h4000_0018; hrdata_i = 32'h0000_00A5;
    tick(); req_i = 1'b0;
    tick(); hready_i = 1'b0; hresp_i = 1'b1;
    tick(); hready_i = 1'b1; hresp_i = 1'b0;
    tick();
    checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'hA5}) begin errors++; $display("FAIL serr_ignored got=%b%b/%h exp=10/000000a5", rvalid_o, err_o, rdata_o); end
    tick();
  endtask

  task automatic test_reset_mid_data();
    req_i = 1'b1; we_i = 1'b1; size_i = 3'd2; addr_i = 32'h4000_001C; wdata_i = 32'h0000_0099; hready_i = 1'b1;
    tick(); req_i = 1'b0;
    tick();
    checks++; if ({hsel_o, hwdata_o} !== {1'b1, 32'h99}) begin errors++; $display("FAIL rst_pre got=%b/%h exp=1/00000099", hsel_o, hwdata_o); end
    #2 hresetn = 1'b0;
    #1;
    checks++; if ({hsel_o, htrans_o, hwrite_o, hsize_o, rvalid_o, gnt_o} !== 9'b0) begin errors++; $display("FAIL rst_ctl got=%b%b%b%b%b%b exp=0", hsel_o, htrans_o, hwrite_o, hsize_o, rvalid_o, gnt_o); end
    checks++; if ({haddr_o, hwdata_o, rdata_o, hburst_o} !== 99'h0) begin errors++; $display("FAIL rst_data got=%h/%h/%h exp=0", haddr_o, hwdata_o, rdata_o); end
    tick();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4000_0020; hrdata_i = 32'h0A0B_0C0D;
    #1;
    checks++; if ({gnt_o, rvalid_o} !== 2'b00) begin errors++; $display("FAIL rst_hold got=%b%b exp=00", gnt_o, rvalid_o); end
    #2 hresetn = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL rst_regnt got=%b exp=1", gnt_o); end
    tick(); req_i = 1'b0;
    checks++; if ({rvalid_o, hsel_o, haddr_o} !== {2'b01, 32'h4000_0020}) begin errors++; $display("FAIL rst_new_addr got=%b%b/%h exp=01/40000020", rvalid_o, hsel_o, haddr_o); end
    tick();
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_stale_rvalid got=%b exp=0", rvalid_o); end
    tick();
    checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h0A0B_0C0D}) begin errors++; $display("FAIL rst_new_resp got=%b%b/%h exp=10/0a0b0c0d", rvalid_o, err_o, rdata_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    req_i = 1'b1; we_i = 1'b0; size_i = 3'd7; addr_i = 32'h4000_0030; hready_i = 1'b1; hrdata_i = 32'h11;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt0 got=%b exp=1", gnt_o); end
    tick();
    checks++; if ({gnt_o, hsize_o} !== {1'b0, 3'd2}) begin errors++; $display("FAIL b2b_c1 got=%b/%0d exp=0/2", gnt_o, hsize_o); end
    tick();
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL b2b_c2_gnt got=%b exp=0", gnt_o); end
    tick();
    checks++; if ({gnt_o, rvalid_o, rdata_o} !== {2'b01, 32'h11}) begin errors++; $display("FAIL b2b_c3 got=%b%b/%h exp=01/00000011", gnt_o, rvalid_o, rdata_o); end
    tick();
    we_i = 1'b1; size_i = 3'd0; addr_i = 32'h4000_0033; wdata_i = 32'h7700_0000;
    #1;
    checks++; if ({gnt_o, rvalid_o} !== 2'b10) begin errors++; $display("FAIL b2b_gnt1 got=%b%b exp=10", gnt_o, rvalid_o); end
    tick(); req_i = 1'b0;
    checks++; if ({hwrite_o, hsize_o, haddr_o} !== {1'b1, 3'd0, 32'h4000_0033}) begin errors++; $display("FAIL b2b_byte_addr got=%b/%0d/%h exp=1/0/40000033", hwrite_o, hsize_o, haddr_o); end
    tick();
    checks++; if (hwdata_o !== 32'h7700_0000) begin errors++; $display("FAIL b2b_hwdata got=%h exp=77000000", hwdata_o); end
    tick();
    checks++; if ({rvalid_o, err_o, rdata_o} !== {2'b10, 32'h0}) begin errors++; $display("FAIL b2b_wr_resp got=%b%b/%h exp=10/0", rvalid_o, err_o, rdata_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_misaligned();
    test_timeout();
    test_slave_error();
    test_reset_mid_data();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_lsu_bridge.md
# ahb_lsu_bridge

AHB-Lite single-master bridge that turns core load/store requests into AHB-Lite SINGLE transfers for the peripheral slaves, including the GPIO block. It sits between the core LSU and the AHB interconnect. It guarantees the slave-side contract: one transfer at a time, and `hsel_o` deasserted for at least one cycle between transfers. It reports bus errors, misaligned accesses and wait-state timeouts back to the core.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- TO_CYCLES, 64, number of hready-low cycles (1..255) per transfer before the transfer is aborted
- hclk  in  1  clock
- hresetn  in  1  reset; asynchronous, active-low; one clock domain (hclk)
- req_i  in  1  core request valid; held until gnt_o
- we_i  in  1  1 = store, 0 = load
- size_i  in  3  0 = byte, 1 = half, 2 = word; other values are treated as word
- addr_i  in  AWIDTH  byte address
- wdata_i  in  DWIDTH  store data, already lane-aligned
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  one-cycle response strobe
- rdata_o  out  DWIDTH  load data; 0 for stores and errors
- err_o  out  1  valid with rvalid_o; 1 = failed access
- hsel_o  out  1  slave select
- haddr_o  out  AWIDTH  address
- htrans_o  out  2  IDLE 2'b00 / NONSEQ 2'b10 only
- hwrite_o  out  1  write
- hsize_o  out  3  transfer size
- hburst_o  out  3  constant 3'b000 (SINGLE)
- hwdata_o  out  DWIDTH  write data
- hready_i  in  1  selected slave's hreadyout
- hresp_i  in  1  selected slave's hresp
- hrdata_i  in  DWIDTH  read data

## Operation
- FSM states: IDLE, ADDR, DATA, GAP. Reset state is IDLE.
- **IDLE**
  - gnt_o = req_i (combinational).
  - On grant, latch we, size, addr and wdata.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0): go to GAP with error flagged. No bus activity.
  - Otherwise go to ADDR.
- **ADDR**
  - Drive hsel_o=1, htrans_o=NONSEQ, and haddr/hwrite/hsize from the latched request.
  - hready_i=1: go to DATA.
- **DATA**
  - hsel_o=1, htrans_o=IDLE.
  - haddr/hwrite/hsize stay held; the slave decodes with hsel_o still high.
  - hwdata_o = latched wdata for writes, 0 otherwise.
  - hready_i=1: capture hrdata_i (reads only), set err = hresp_i, go to GAP.
- **GAP**
  - hsel_o=0, htrans_o=IDLE, haddr_o=0, hwrite_o=0, hsize_o=0, hwdata_o=0.
  - rvalid_o=1 for exactly this one cycle, with err_o and rdata_o valid.
  - On err, rdata_o = 0.
  - Next state is always IDLE. gnt_o is 0 in GAP.
- **Timeout**
  - The counter clears on entry to ADDR.
  - It increments on each ADDR or DATA cycle with hready_i=0; the count is cumulative across both states.
  - When the count reaches TO_CYCLES: abort to GAP with err=1 and drop hsel/htrans at once.
- rvalid_o, err_o and rdata_o are registered; all zero outside GAP.
- hburst_o is tied to 3'b000.
- Reset mid-operation: FSM returns to IDLE and all outputs go to 0. The interrupted request produces no response; the core must re-issue it.

## Timing
- Zero-wait transfer, core view:
  - C0: IDLE, gnt.
  - C1: ADDR.
  - C2: DATA.
  - C3: GAP with rvalid.
  - C4: IDLE, next gnt possible.
- Minimum spacing between grants is 4 cycles.
- Each wait state (hready_i=0) in ADDR or DATA adds one cycle.
- Misaligned access: grant in C0, rvalid+err in C1, next grant in C2.
- req_i is sampled only in IDLE; requests raised in other states wait.
- hresp_i is ignored unless hready_i=1 in DATA.
- Reset values: gnt_o=0, rvalid_o=0, err_o=0, rdata_o=0, hsel_o=0, htrans_o=2'b00, hwrite_o=0, hsize_o=0, hburst_o=0, haddr_o=0, hwdata_o=0.

## Test plan
- **Zero-wait word read:** addr 0x40000000, hrdata_i=0x00000003, hready_i=1 → gnt C0, NONSEQ in C1, rvalid C3 with rdata 0x3 and err 0, hsel_o low in C3.
- **Word write with 2 wait states:** addr 0x40000004, wdata 0x5, hready_i low for 2 cycles in DATA → hwdata_o=0x5 held through DATA, rvalid C5 with err 0 and rdata 0.
- **Misaligned word load:** addr 0x40000002 → hsel_o never asserts, rvalid+err_o=1 in C1, rdata 0.
- **Timeout:** TO_CYCLES=8, hready_i stuck 0 → abort after 8 hready-low cycles, then one rvalid with err 1, then back in IDLE. A later request completes normally.
- **Slave error:** hresp_i=1 with hready_i=1 in DATA → err_o=1 with rvalid_o, rdata 0.
- **Reset mid-DATA:** hresetn low during DATA → all outputs 0 immediately, no rvalid after release. A back-to-back request after release is granted in the first IDLE cycle.
